// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage with req/gnt/rvalid data bus, timeout, branch select and MEM/WB register
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Mem_Read_EX_MEM,
  input  logic        Mem_Write_EX_MEM,
  input  logic        PcSrc_EX_MEM,
  input  logic        zero_EX_MEM,
  input  logic        Mem_to_Reg_EX_MEM,
  input  logic        Reg_Write_EX_MEM,
  input  logic [31:0] PC_Branch_EX_MEM,
  input  logic [31:0] result_EX_MEM,
  input  logic [31:0] Write_Data_EX_MEM,
  input  logic [4:0]  rd_EX_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        stall_MEM,
  output logic        PcSrc_MEM,
  output logic [31:0] PC_Branch_MEM,
  output logic        mem_err,
  output logic        Reg_Write_MEM_WB,
  output logic        Mem_to_Reg_MEM_WB,
  output logic [31:0] Read_Data_MEM_WB,
  output logic [31:0] result_MEM_WB,
  output logic [4:0]  rd_MEM_WB
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic acc, bad, done, bubble, ld_done, set_err;
  assign acc = Mem_Read_EX_MEM | Mem_Write_EX_MEM;
  assign bad = (result_EX_MEM[1:0] != 2'b00) | (Mem_Read_EX_MEM & Mem_Write_EX_MEM);
  assign dmem_we = Mem_Write_EX_MEM;
  assign dmem_addr = result_EX_MEM;
  assign dmem_wdata = Write_Data_EX_MEM;
  assign stall_MEM = acc & ~done;
  assign PcSrc_MEM = PcSrc_EX_MEM & zero_EX_MEM;
  assign PC_Branch_MEM = PC_Branch_EX_MEM;
  // bus handshake sequencing; an expired access is forced to finish as a bubble
  always_comb begin
    nxt = state;
    dmem_req = 1'b0;
    done = 1'b0;
    bubble = 1'b0;
    ld_done = 1'b0;
    set_err = 1'b0;
    case (state)
      IDLE: if (acc) begin
        if (bad) begin
          set_err = 1'b1;
          done = 1'b1;
          bubble = 1'b1;
        end else begin
          dmem_req = 1'b1;
          if (!dmem_gnt) nxt = REQ;
          else if (Mem_Read_EX_MEM) nxt = WAIT;
          else done = 1'b1;
        end
      end
      REQ: begin
        dmem_req = 1'b1;
        if (dmem_gnt) begin
          nxt = Mem_Read_EX_MEM ? WAIT : IDLE;
          done = ~Mem_Read_EX_MEM;
        end
      end
      WAIT: if (dmem_rvalid) begin
        nxt = IDLE;
        done = 1'b1;
        ld_done = 1'b1;
      end
      default: nxt = IDLE;
    endcase
    if (state != IDLE && !done && cnt == CW'(TIMEOUT_CYCLES - 1)) begin
      nxt = IDLE;
      done = 1'b1;
      bubble = 1'b1;
      set_err = 1'b1;
    end
  end
  // state, timeout counter and sticky error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      mem_err <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= (state == IDLE) ? '0 : cnt + CW'(1);
      mem_err <= mem_err | set_err;
    end
  end
  // MEM/WB register: bubble while stalled, capture on completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Reg_Write_MEM_WB <= 1'b0;
      Mem_to_Reg_MEM_WB <= 1'b0;
      Read_Data_MEM_WB <= '0;
      result_MEM_WB <= '0;
      rd_MEM_WB <= '0;
    end else if (stall_MEM) begin
      Reg_Write_MEM_WB <= 1'b0;
    end else begin
      Reg_Write_MEM_WB <= Reg_Write_EX_MEM & ~bubble;
      Mem_to_Reg_MEM_WB <= Mem_to_Reg_EX_MEM;
      Read_Data_MEM_WB <= ld_done ? dmem_rdata : '0;
      result_MEM_WB <= result_EX_MEM;
      rd_MEM_WB <= rd_EX_MEM;
    end
  end
endmodule
